reorder_buffer: RTL

//   Circular reorder buffer: allocates a tag per issued instruction, collects results from the CDB,
//   and retires strictly in program order. Sole driver of the register file's commit interface
//   (rob_set_idx/rob_set_reg_val/rob_set_recorder, rob_clear) and of the front-end redirect on a

---
 rtl/reorder_buffer_if.sv | 51 +++++
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, CDB, operand query, commit and redirect signal bundle of the reorder buffer
interface reorder_buffer_if #(
    parameter int ROB_SIZE_BIT = 4
);
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic                    issue_done;
    logic [31:0]             issue_val;
    logic [ROB_SIZE_BIT-1:0] issue_tag;
    logic                    full;

    logic                    cdb_valid;
    logic [ROB_SIZE_BIT-1:0] cdb_tag;
    logic [31:0]             cdb_val;
    logic                    cdb_redirect;
    logic [31:0]             cdb_pc;

    logic [ROB_SIZE_BIT-1:0] query_tag1;
    logic [ROB_SIZE_BIT-1:0] query_tag2;
    logic                    query_ready1;
    logic                    query_ready2;
    logic [31:0]             query_val1;
    logic [31:0]             query_val2;

    logic [4:0]              rob_set_idx;
    logic [31:0]             rob_set_reg_val;
    logic [ROB_SIZE_BIT-1:0] rob_set_recorder;
    logic                    rob_clear;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;

    modport slave (
        input  issue_valid, issue_rd, issue_done, issue_val,
        output issue_tag, full,
        input  cdb_valid, cdb_tag, cdb_val, cdb_redirect, cdb_pc,
        input  query_tag1, query_tag2,
        output query_ready1, query_ready2, query_val1, query_val2,
        output rob_set_idx, rob_set_reg_val, rob_set_recorder, rob_clear,
        output redirect_valid, redirect_pc
    );

    modport master (
        output issue_valid, issue_rd, issue_done, issue_val,
        input  issue_tag, full,
        output cdb_valid, cdb_tag, cdb_val, cdb_redirect, cdb_pc,
        output query_tag1, query_tag2,
        input  query_ready1, query_ready2, query_val1, query_val2,
        input  rob_set_idx, rob_set_reg_val, rob_set_recorder, rob_clear,
        input  redirect_valid, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with in-order commit and mispredict flush sequencing
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reorder_buffer_if.slave   rob
);
    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] COUNT_FULL = (ROB_SIZE_BIT+1)'(ROB_SIZE);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;
    logic [31:0]             flush_pc;

    logic [ROB_SIZE-1:0] ent_busy;
    logic [ROB_SIZE-1:0] ent_done;
    logic [ROB_SIZE-1:0] ent_redirect;
    logic [4:0]          ent_rd  [ROB_SIZE];
    logic [31:0]         ent_val [ROB_SIZE];
    logic [31:0]         ent_pc  [ROB_SIZE];

    logic issue_go;
    logic commit_go;
    logic flush_go;

    // Any non-RUN state blocks allocation, so the front end stalls through the flush.
    assign rob.full     = (count == COUNT_FULL) || (state != RUN);
    assign rob.issue_tag = tail;

    assign issue_go  = rob.issue_valid && !rob.full;
    assign commit_go = (state == RUN) && ent_busy[head] && ent_done[head];
    assign flush_go  = commit_go && ent_redirect[head];

    // Operand lookup reads the stored entry only; a same-cycle CDB result is not forwarded.
    assign rob.query_ready1 = ent_busy[rob.query_tag1] && ent_done[rob.query_tag1];
    assign rob.query_ready2 = ent_busy[rob.query_tag2] && ent_done[rob.query_tag2];
    assign rob.query_val1   = ent_val[rob.query_tag1];
    assign rob.query_val2   = ent_val[rob.query_tag2];

    // Flush sequencer next state: a mispredicted commit walks RUN -> DRAIN -> CLEAR -> RUN.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush_go) state_next = DRAIN;
            DRAIN:   state_next = CLEAR;
            CLEAR:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Flush sequencer state register, frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= RUN;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Entry storage, pointers and the registered commit/clear/redirect outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            flush_pc             <= '0;
            ent_busy             <= '0;
            ent_done             <= '0;
            ent_redirect         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_rd[i]  <= '0;
                ent_val[i] <= '0;
                ent_pc[i]  <= '0;
            end
            rob.rob_set_idx      <= '0;
            rob.rob_set_reg_val  <= '0;
            rob.rob_set_recorder <= '0;
            rob.rob_clear        <= 1'b0;
            rob.redirect_valid   <= 1'b0;
            rob.redirect_pc      <= '0;
        end else if (rdy_in) begin
            case (state)
                RUN: begin
                    // Completion only lands on live entries; stale tags fall on the floor.
                    if (rob.cdb_valid && ent_busy[rob.cdb_tag]) begin
                        ent_done[rob.cdb_tag]     <= 1'b1;
                        ent_val[rob.cdb_tag]      <= rob.cdb_val;
                        ent_redirect[rob.cdb_tag] <= rob.cdb_redirect;
                        ent_pc[rob.cdb_tag]       <= rob.cdb_pc;
                    end
                    if (issue_go) begin
                        ent_busy[tail]     <= 1'b1;
                        ent_done[tail]     <= rob.issue_done;
                        ent_rd[tail]       <= rob.issue_rd;
                        ent_val[tail]      <= rob.issue_val;
                        ent_redirect[tail] <= 1'b0;
                        tail               <= tail + 1'b1;
                    end
                    if (commit_go) begin
                        rob.rob_set_idx      <= ent_rd[head];
                        rob.rob_set_reg_val  <= ent_val[head];
                        rob.rob_set_recorder <= head;
                        ent_busy[head]       <= 1'b0;
                        head                 <= head + 1'b1;
                    end else begin
                        rob.rob_set_idx <= '0;
                    end
                    count <= count + (ROB_SIZE_BIT+1)'(issue_go) - (ROB_SIZE_BIT+1)'(commit_go);
                    // The mispredicted entry still writes back; everything younger is discarded,
                    // including anything allocated on this same edge.
                    if (flush_go) begin
                        ent_busy <= '0;
                        head     <= '0;
                        tail     <= '0;
                        count    <= '0;
                        flush_pc <= ent_pc[head];
                    end
                end
                DRAIN: begin
                    // The register write from the flushing commit lands one cycle before the clear.
                    rob.rob_set_idx    <= '0;
                    rob.rob_clear      <= 1'b1;
                    rob.redirect_valid <= 1'b1;
                    rob.redirect_pc    <= flush_pc;
                end
                CLEAR: begin
                    rob.rob_clear      <= 1'b0;
                    rob.redirect_valid <= 1'b0;
                end
                default: begin
                    rob.rob_clear      <= 1'b0;
                    rob.redirect_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
